// File: rtl/router_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | router_pkg : state encoding, control-word decode and parameter check     |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
package router_pkg;

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        LOAD_DATA          = 4'd2,
        FIFO_FULL_STATE    = 4'd3,
        LOAD_AFTER_FULL    = 4'd4,
        LOAD_PARITY        = 4'd5,
        CHECK_PARITY_ERROR = 4'd6,
        WAIT_TILL_EMPTY    = 4'd7,
        DROP_PACKET        = 4'd8
    } state_t;

    typedef struct packed {
        logic detect_add;
        logic lfd;
        logic ld;
        logic laf;
        logic full;
        logic write_enb;
        logic rst_int;
        logic busy;
        logic drop;
    } ctrl_t;

    function automatic bit addr_fits(input int num_ch, input int addr_w);
        return (num_ch >= 2) && (num_ch <= 16) && ((1 << addr_w) >= num_ch);
    endfunction

    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            DECODE_ADDRESS:     c.detect_add = 1'b1;
            WAIT_TILL_EMPTY:    c.busy = 1'b1;
            LOAD_FIRST_DATA:    begin c.lfd = 1'b1; c.busy = 1'b1; c.write_enb = 1'b1; end
            LOAD_DATA:          begin c.ld = 1'b1; c.write_enb = 1'b1; end
            FIFO_FULL_STATE:    begin c.full = 1'b1; c.busy = 1'b1; end
            LOAD_AFTER_FULL:    begin c.laf = 1'b1; c.busy = 1'b1; c.write_enb = 1'b1; end
            LOAD_PARITY:        begin c.busy = 1'b1; c.write_enb = 1'b1; end
            CHECK_PARITY_ERROR: begin c.rst_int = 1'b1; c.busy = 1'b1; end
            DROP_PACKET:        c.drop = 1'b1;
            default:            c.detect_add = 1'b1;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_wait_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | router_wait_timer : clearable saturating counter, tc on last wait cycle  |
// | Revision          : 1.0                                                  |
// +--------------------------------------------------------------------------+
module router_wait_timer #(
    parameter int MAX = 255,
    parameter int W   = 8
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [W-1:0] r_count;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != W'(MAX))) begin
            r_count <= r_count + W'(1);
        end
    end

    // Fires on the MAX-th enabled cycle so the waiting state lasts exactly MAX cycles.
    assign tc = (MAX != 0) && enable && (r_count == W'(MAX - 1));

endmodule
`default_nettype wire

// File: rtl/router_fsm_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | router_fsm_param : router control FSM steering NUM_CH destination FIFOs  |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module router_fsm_param
    import router_pkg::*;
#(
    parameter int NUM_CH       = 3,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic [NUM_CH-1:0] soft_reset,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic [ADDR_W-1:0] dest_sel,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg,
    output logic              busy,
    output logic              drop_state
);

    localparam int NSEL = 1 << ADDR_W;
    localparam int TW   = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;

    if (!addr_fits(NUM_CH, ADDR_W)) begin : g_param_check
        $error("router_fsm_param: ADDR_W too narrow for NUM_CH or NUM_CH out of range");
    end

    state_t            r_state;
    state_t            w_next;
    ctrl_t             r_ctrl;
    logic [ADDR_W-1:0] r_dest_sel;
    logic              r_pkt_valid_q;
    logic              r_full_q;
    logic [NSEL-1:0]   w_empty_ext;
    logic [NSEL-1:0]   w_soft_ext;
    logic              w_sop;
    logic              w_addr_ok;
    logic              w_timeout;

    // Zero-padded to the full address space so unused addresses read as not-empty / no reset.
    assign w_empty_ext = NSEL'(fifo_empty);
    assign w_soft_ext  = NSEL'(soft_reset);
    assign w_sop       = pkt_valid & ~r_pkt_valid_q;
    assign w_addr_ok   = int'(data_in) < NUM_CH;

    router_wait_timer #(
        .MAX (WAIT_TIMEOUT),
        .W   (TW)
    ) u_wait_timer (
        .clock  (clock),
        .resetn (resetn),
        .clear  (r_state == DECODE_ADDRESS),
        .enable (r_state == WAIT_TILL_EMPTY),
        .tc     (w_timeout)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            DECODE_ADDRESS: begin
                if (w_sop) begin
                    if (!w_addr_ok)                w_next = DROP_PACKET;
                    else if (w_empty_ext[data_in]) w_next = LOAD_FIRST_DATA;
                    else                           w_next = WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (w_empty_ext[r_dest_sel]) w_next = LOAD_FIRST_DATA;
                else if (w_timeout)          w_next = DROP_PACKET;
            end
            LOAD_FIRST_DATA: w_next = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       w_next = FIFO_FULL_STATE;
                else if (!pkt_valid) w_next = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) w_next = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)        w_next = DECODE_ADDRESS;
                else if (low_pkt_valid) w_next = LOAD_PARITY;
                else                    w_next = LOAD_DATA;
            end
            LOAD_PARITY:        w_next = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: w_next = r_full_q ? FIFO_FULL_STATE : DECODE_ADDRESS;
            DROP_PACKET: begin
                if (!pkt_valid) w_next = DECODE_ADDRESS;
            end
            default: w_next = DECODE_ADDRESS;
        endcase
        if ((r_state != DECODE_ADDRESS) && w_soft_ext[r_dest_sel]) begin
            w_next = DECODE_ADDRESS;
        end
    end

    // Outputs are registered from the next state, so they track the state register exactly.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state       <= DECODE_ADDRESS;
            r_ctrl        <= decode_ctrl(DECODE_ADDRESS);
            r_dest_sel    <= '0;
            r_pkt_valid_q <= 1'b0;
            r_full_q      <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_ctrl        <= decode_ctrl(w_next);
            r_pkt_valid_q <= pkt_valid;
            if ((r_state == DECODE_ADDRESS) && w_sop) begin
                r_dest_sel <= data_in;
            end
            if (r_state == LOAD_PARITY) begin
                r_full_q <= fifo_full;
            end
        end
    end

    assign dest_sel      = r_dest_sel;
    assign detect_add    = r_ctrl.detect_add;
    assign lfd_state     = r_ctrl.lfd;
    assign ld_state      = r_ctrl.ld;
    assign laf_state     = r_ctrl.laf;
    assign full_state    = r_ctrl.full;
    assign write_enb_reg = r_ctrl.write_enb;
    assign rst_int_reg   = r_ctrl.rst_int;
    assign busy          = r_ctrl.busy;
    assign drop_state    = r_ctrl.drop;

endmodule
`default_nettype wire

// File: tb/tb_router_fsm_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_router_fsm_param : randomized scenario bench for router_fsm_param     |
// | Revision            : 1.0                                                |
// +--------------------------------------------------------------------------+
module tb_router_fsm_param;

    localparam int NUM_CH = 3;
    localparam int ADDR_W = 2;

    localparam int P_DEC  = 0;
    localparam int P_WAIT = 1;
    localparam int P_LFD  = 2;
    localparam int P_LD   = 3;
    localparam int P_FULL = 4;
    localparam int P_LAF  = 5;
    localparam int P_PAR  = 6;
    localparam int P_CHK  = 7;
    localparam int P_DROP = 8;
    localparam int P_BAD  = 15;

    logic              clock = 1'b0;
    logic              resetn = 1'b1;
    logic              pkt_valid = 1'b0;
    logic [ADDR_W-1:0] data_in = '0;
    logic              fifo_full = 1'b0;
    logic [NUM_CH-1:0] fifo_empty = '1;
    logic [NUM_CH-1:0] soft_reset = '0;
    logic              parity_done = 1'b0;
    logic              low_pkt_valid = 1'b0;

    logic [ADDR_W-1:0] dest_sel, t_dest_sel;
    logic detect_add, lfd_state, ld_state, laf_state, full_state;
    logic write_enb_reg, rst_int_reg, busy, drop_state;
    logic t_detect_add, t_lfd_state, t_ld_state, t_laf_state, t_full_state;
    logic t_write_enb_reg, t_rst_int_reg, t_busy, t_drop_state;

    int checks   = 0;
    int failures = 0;

    router_fsm_param #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .dest_sel(dest_sel),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
        .rst_int_reg(rst_int_reg), .busy(busy), .drop_state(drop_state)
    );

    router_fsm_param #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .WAIT_TIMEOUT(4)) dut_to (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .dest_sel(t_dest_sel),
        .detect_add(t_detect_add), .lfd_state(t_lfd_state), .ld_state(t_ld_state),
        .laf_state(t_laf_state), .full_state(t_full_state), .write_enb_reg(t_write_enb_reg),
        .rst_int_reg(t_rst_int_reg), .busy(t_busy), .drop_state(t_drop_state)
    );

    always #5 clock = ~clock;

    // Phase recognised from the full output pattern {detect,lfd,ld,laf,full,drop,rst_int,busy,we}.
    function automatic int phase_of(input logic [8:0] v);
        case (v)
            9'b100000000: return P_DEC;
            9'b000000010: return P_WAIT;
            9'b010000011: return P_LFD;
            9'b001000001: return P_LD;
            9'b000010010: return P_FULL;
            9'b000100011: return P_LAF;
            9'b000000011: return P_PAR;
            9'b000000110: return P_CHK;
            9'b000001000: return P_DROP;
            default:      return P_BAD;
        endcase
    endfunction

    function automatic int ph();
        return phase_of({detect_add, lfd_state, ld_state, laf_state, full_state,
                         drop_state, rst_int_reg, busy, write_enb_reg});
    endfunction

    function automatic int ph_to();
        return phase_of({t_detect_add, t_lfd_state, t_ld_state, t_laf_state, t_full_state,
                         t_drop_state, t_rst_int_reg, t_busy, t_write_enb_reg});
    endfunction

    function automatic string pname(input int p);
        case (p)
            P_DEC: return "DECODE";  P_WAIT: return "WAIT";   P_LFD: return "LFD";
            P_LD:  return "LD";      P_FULL: return "FULL";   P_LAF: return "LAF";
            P_PAR: return "PARITY";  P_CHK:  return "CHECK";  P_DROP: return "DROP";
            default: return "ILLEGAL";
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        pkt_valid = 1'b0; data_in = '0; fifo_full = 1'b0; fifo_empty = '1;
        soft_reset = '0; parity_done = 1'b0; low_pkt_valid = 1'b0;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #1 resetn = 1'b0;
        #2;
        checks++;
        if ({detect_add, lfd_state, ld_state, laf_state, full_state, drop_state,
             rst_int_reg, busy, write_enb_reg} !== 9'b100000000 || dest_sel !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got detect=%b lfd=%b ld=%b laf=%b full=%b drop=%b rst_int=%b busy=%b we=%b dest=%0d, want detect=1 others=0 dest=0",
                     detect_add, lfd_state, ld_state, laf_state, full_state, drop_state,
                     rst_int_reg, busy, write_enb_reg, dest_sel);
        end
        tick();
        resetn = 1'b1;
        repeat (3) tick();
        checks++;
        if (ph() !== P_DEC) begin
            failures++;
            $display("FAIL reset_idle: got %s want DECODE", pname(ph()));
        end
    endtask

    task automatic test_basic_packet();
        int exp_q[$];
        int obs_q[$];
        int len, we_cnt;
        logic [ADDR_W-1:0] dest;
        do_reset();
        for (int r = 0; r < 4; r++) begin
            dest = (r == 0) ? ADDR_W'(1) : ADDR_W'($urandom_range(0, NUM_CH - 1));
            len  = (r == 0) ? 4 : int'($urandom_range(1, 6));
            exp_q = {}; obs_q = {}; we_cnt = 0;
            exp_q.push_back(P_LFD);
            repeat (len) exp_q.push_back(P_LD);
            exp_q.push_back(P_PAR); exp_q.push_back(P_CHK); exp_q.push_back(P_DEC);
            pkt_valid = 1'b1; data_in = dest;
            tick();
            obs_q.push_back(ph()); we_cnt += (write_enb_reg === 1'b1) ? 1 : 0;
            data_in = ~dest;
            checks++;
            if (dest_sel !== dest) begin
                failures++;
                $display("FAIL basic_dest_sel r=%0d: got %0d want %0d", r, dest_sel, dest);
            end
            for (int k = 1; k <= len; k++) begin
                tick();
                obs_q.push_back(ph()); we_cnt += (write_enb_reg === 1'b1) ? 1 : 0;
                pkt_valid = (k < len);
            end
            repeat (3) begin
                tick();
                obs_q.push_back(ph()); we_cnt += (write_enb_reg === 1'b1) ? 1 : 0;
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL basic_seq r=%0d cyc=%0d: got %s want %s", r, i, pname(obs_q[i]), pname(exp_q[i]));
                end
            end
            checks++;
            if (we_cnt !== len + 2) begin
                failures++;
                $display("FAIL basic_write_count r=%0d: got %0d want %0d", r, we_cnt, len + 2);
            end
        end
    endtask

    task automatic test_wait_empty();
        int exp_q[$];
        int obs_q[$];
        int w, busy_cnt;
        logic [ADDR_W-1:0] dest;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            dest = (r == 0) ? ADDR_W'(2) : ADDR_W'($urandom_range(0, NUM_CH - 1));
            w    = (r == 0) ? 10 : int'($urandom_range(1, 12));
            exp_q = {}; obs_q = {}; busy_cnt = 0;
            repeat (w) exp_q.push_back(P_WAIT);
            exp_q.push_back(P_LFD); exp_q.push_back(P_LD); exp_q.push_back(P_PAR);
            exp_q.push_back(P_CHK); exp_q.push_back(P_DEC);
            fifo_empty = '1; fifo_empty[dest] = 1'b0;
            pkt_valid = 1'b1; data_in = dest;
            for (int i = 1; i <= w; i++) begin
                tick();
                obs_q.push_back(ph()); busy_cnt += (busy === 1'b1) ? 1 : 0;
                if (i == w) fifo_empty[dest] = 1'b1;
            end
            tick(); obs_q.push_back(ph());
            tick(); obs_q.push_back(ph());
            pkt_valid = 1'b0;
            repeat (3) begin tick(); obs_q.push_back(ph()); end
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL wait_seq r=%0d cyc=%0d: got %s want %s", r, i, pname(obs_q[i]), pname(exp_q[i]));
                end
            end
            checks++;
            if (busy_cnt !== w) begin
                failures++;
                $display("FAIL wait_busy_cycles r=%0d: got %0d want %0d", r, busy_cnt, w);
            end
        end
    endtask

    task automatic test_timeout();
        int exp_q[$];
        int obs_q[$];
        int we_cnt, d, e;
        bit drop_mode;
        logic [ADDR_W-1:0] dest;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            drop_mode = (r % 2 == 0);
            dest = (r == 0) ? ADDR_W'(0) : ADDR_W'($urandom_range(0, NUM_CH - 1));
            d = int'($urandom_range(0, 3));
            e = (r == 1) ? 4 : int'($urandom_range(1, 4));
            exp_q = {}; obs_q = {}; we_cnt = 0;
            fifo_empty = '1; fifo_empty[dest] = 1'b0;
            pkt_valid = 1'b1; data_in = dest;
            if (drop_mode) begin
                repeat (4) exp_q.push_back(P_WAIT);
                repeat (d + 1) exp_q.push_back(P_DROP);
                exp_q.push_back(P_DEC);
                for (int i = 1; i <= 4; i++) begin
                    tick(); obs_q.push_back(ph_to()); we_cnt += (t_write_enb_reg === 1'b1) ? 1 : 0;
                end
                for (int j = 0; j <= d; j++) begin
                    tick(); obs_q.push_back(ph_to()); we_cnt += (t_write_enb_reg === 1'b1) ? 1 : 0;
                    if (j == d) pkt_valid = 1'b0;
                end
                tick(); obs_q.push_back(ph_to()); we_cnt += (t_write_enb_reg === 1'b1) ? 1 : 0;
                checks++;
                if (we_cnt !== 0) begin
                    failures++;
                    $display("FAIL timeout_no_writes r=%0d: got %0d write cycles want 0", r, we_cnt);
                end
            end else begin
                repeat (e) exp_q.push_back(P_WAIT);
                exp_q.push_back(P_LFD); exp_q.push_back(P_LD); exp_q.push_back(P_PAR);
                exp_q.push_back(P_CHK); exp_q.push_back(P_DEC);
                for (int i = 1; i <= e; i++) begin
                    tick(); obs_q.push_back(ph_to());
                    if (i == e) fifo_empty[dest] = 1'b1;
                end
                tick(); obs_q.push_back(ph_to());
                tick(); obs_q.push_back(ph_to());
                pkt_valid = 1'b0;
                repeat (3) begin tick(); obs_q.push_back(ph_to()); end
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL timeout_seq r=%0d cyc=%0d: got %s want %s", r, i, pname(obs_q[i]), pname(exp_q[i]));
                end
            end
        end
    endtask

    task automatic test_invalid_addr();
        int exp_q[$];
        int obs_q[$];
        int we_cnt, d;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            d = int'($urandom_range(0, 4));
            exp_q = {}; obs_q = {}; we_cnt = 0;
            repeat (d + 1) exp_q.push_back(P_DROP);
            exp_q.push_back(P_DEC);
            fifo_empty = NUM_CH'($urandom);
            pkt_valid = 1'b1; data_in = ADDR_W'(3);
            for (int j = 0; j <= d; j++) begin
                tick(); obs_q.push_back(ph()); we_cnt += (write_enb_reg === 1'b1) ? 1 : 0;
                if (j == d) pkt_valid = 1'b0;
            end
            tick(); obs_q.push_back(ph()); we_cnt += (write_enb_reg === 1'b1) ? 1 : 0;
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL invalid_seq r=%0d cyc=%0d: got %s want %s", r, i, pname(obs_q[i]), pname(exp_q[i]));
                end
            end
            checks++;
            if (we_cnt !== 0 || dest_sel !== ADDR_W'(3)) begin
                failures++;
                $display("FAIL invalid_writes r=%0d: got writes=%0d dest=%0d want writes=0 dest=3", r, we_cnt, dest_sel);
            end
        end
    endtask

    task automatic test_full_stall();
        int exp_q[$];
        int obs_q[$];
        int s;
        logic [ADDR_W-1:0] dest;
        for (int v = 0; v < 3; v++) begin
            do_reset();
            dest = ADDR_W'($urandom_range(0, NUM_CH - 1));
            s = (v == 0) ? 3 : int'($urandom_range(1, 5));
            exp_q = {}; obs_q = {};
            exp_q.push_back(P_LFD); exp_q.push_back(P_LD);
            repeat (s) exp_q.push_back(P_FULL);
            exp_q.push_back(P_LAF);
            if (v == 0) exp_q.push_back(P_DEC);
            if (v == 2) exp_q.push_back(P_LD);
            if (v != 0) begin
                exp_q.push_back(P_PAR); exp_q.push_back(P_CHK); exp_q.push_back(P_DEC);
            end
            pkt_valid = 1'b1; data_in = dest;
            tick(); obs_q.push_back(ph());
            tick(); obs_q.push_back(ph());
            fifo_full = 1'b1;
            if (v == 1) pkt_valid = 1'b0;
            for (int j = 1; j <= s; j++) begin
                tick(); obs_q.push_back(ph());
                if (j == s) fifo_full = 1'b0;
            end
            tick(); obs_q.push_back(ph());
            if (v == 0) begin
                parity_done = 1'b1;
                tick(); obs_q.push_back(ph());
                parity_done = 1'b0; pkt_valid = 1'b0;
            end else if (v == 1) begin
                low_pkt_valid = 1'b1;
                tick(); obs_q.push_back(ph());
                low_pkt_valid = 1'b0;
                repeat (2) begin tick(); obs_q.push_back(ph()); end
            end else begin
                tick(); obs_q.push_back(ph());
                pkt_valid = 1'b0;
                repeat (3) begin tick(); obs_q.push_back(ph()); end
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL full_seq v=%0d cyc=%0d: got %s want %s", v, i, pname(obs_q[i]), pname(exp_q[i]));
                end
            end
        end
    endtask

    task automatic test_check_full();
        int exp_q[$];
        int obs_q[$];
        do_reset();
        exp_q = '{P_LFD, P_LD, P_PAR, P_CHK, P_FULL, P_LAF, P_DEC};
        pkt_valid = 1'b1; data_in = ADDR_W'($urandom_range(0, NUM_CH - 1));
        tick(); obs_q.push_back(ph());
        tick(); obs_q.push_back(ph());
        pkt_valid = 1'b0;
        tick(); obs_q.push_back(ph());
        fifo_full = 1'b1;
        tick(); obs_q.push_back(ph());
        tick(); obs_q.push_back(ph());
        fifo_full = 1'b0;
        tick(); obs_q.push_back(ph());
        parity_done = 1'b1;
        tick(); obs_q.push_back(ph());
        parity_done = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL check_full_seq cyc=%0d: got %s want %s", i, pname(obs_q[i]), pname(exp_q[i]));
            end
        end
    endtask

    task automatic test_soft_reset();
        int exp_q[$];
        int obs_q[$];
        int other;
        logic [ADDR_W-1:0] dest, dest2;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            dest  = (r == 0) ? ADDR_W'(1) : ADDR_W'($urandom_range(0, NUM_CH - 1));
            other = (r == 0) ? 2 : (int'(dest) + 1 + int'($urandom_range(0, 1))) % NUM_CH;
            dest2 = ADDR_W'($urandom_range(0, NUM_CH - 1));
            exp_q = '{P_LFD, P_LD, P_LD, P_DEC, P_DEC, P_LFD, P_LD, P_PAR, P_CHK, P_DEC};
            obs_q = {};
            pkt_valid = 1'b1; data_in = dest;
            tick(); obs_q.push_back(ph());
            tick(); obs_q.push_back(ph());
            soft_reset = NUM_CH'(1) << other;
            tick(); obs_q.push_back(ph());
            soft_reset = NUM_CH'(1) << dest;
            tick(); obs_q.push_back(ph());
            soft_reset = '1; pkt_valid = 1'b0;
            tick(); obs_q.push_back(ph());
            soft_reset = NUM_CH'(1) << dest2; pkt_valid = 1'b1; data_in = dest2;
            tick(); obs_q.push_back(ph());
            soft_reset = '0;
            tick(); obs_q.push_back(ph());
            pkt_valid = 1'b0;
            repeat (3) begin tick(); obs_q.push_back(ph()); end
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL soft_reset_seq r=%0d cyc=%0d: got %s want %s", r, i, pname(obs_q[i]), pname(exp_q[i]));
                end
            end
        end
    endtask

    task automatic test_async_abort();
        int n;
        for (int r = 0; r < 2; r++) begin
            do_reset();
            n = int'($urandom_range(1, 3));
            pkt_valid = 1'b1; data_in = ADDR_W'($urandom_range(1, NUM_CH - 1));
            repeat (n + 1) tick();
            checks++;
            if (ph() !== P_LD) begin
                failures++;
                $display("FAIL abort_pre r=%0d: got %s want LD", r, pname(ph()));
            end
            #2 resetn = 1'b0;
            #1;
            checks++;
            if ({detect_add, lfd_state, ld_state, laf_state, full_state, drop_state,
                 rst_int_reg, busy, write_enb_reg} !== 9'b100000000 || dest_sel !== '0) begin
                failures++;
                $display("FAIL abort_immediate r=%0d: got %s dest=%0d want DECODE dest=0", r, pname(ph()), dest_sel);
            end
            pkt_valid = 1'b0;
            tick();
            resetn = 1'b1;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic_packet();
        test_wait_empty();
        test_timeout();
        test_invalid_addr();
        test_full_stall();
        test_check_full();
        test_soft_reset();
        test_async_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
